// File: rtl/serial_fadd_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding.
package serial_fadd_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_fadd_fadd.sv
// Combinational full-adder cell; interface mirrors the fsub cell.
module fadd (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_fadd.sv
// Bit-serial WIDTH-bit adder: LSB-first through one full-adder cell,
// result registered on the last bit with a one-cycle done pulse.
module serial_fadd
  import serial_fadd_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] sra_reg, srb_reg, acc_reg, sum_reg;
  logic [CW-1:0]    cnt_reg;
  logic             carry_reg, cout_reg, busy_reg;
  logic             s_bit, c_bit;
  logic [WIDTH-1:0] acc_shift;

  fadd u_fadd (
    .a    (sra_reg[0]),
    .b    (srb_reg[0]),
    .cin  (carry_reg),
    .s    (s_bit),
    .cout (c_bit)
  );

  // New sum bit enters at the MSB so after WIDTH shifts bit 0 is the LSB.
  assign acc_shift = {s_bit, acc_reg[WIDTH-1:1]};

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: if (start) state_next = S_RUN;
      S_RUN:  if (cnt_reg == CNT_LAST) state_next = S_DONE;
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      busy_reg  <= 1'b0;
      sra_reg   <= '0;
      srb_reg   <= '0;
      acc_reg   <= '0;
      carry_reg <= 1'b0;
      cnt_reg   <= '0;
      sum_reg   <= '0;
      cout_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      busy_reg  <= (state_next != S_IDLE);
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            sra_reg   <= a;
            srb_reg   <= b;
            carry_reg <= cin;
            cnt_reg   <= '0;
            acc_reg   <= '0;
          end
        end
        S_RUN: begin
          acc_reg   <= acc_shift;
          sra_reg   <= {1'b0, sra_reg[WIDTH-1:1]};
          srb_reg   <= {1'b0, srb_reg[WIDTH-1:1]};
          carry_reg <= c_bit;
          cnt_reg   <= cnt_reg + 1'b1;
          if (cnt_reg == CNT_LAST) begin
            sum_reg  <= acc_shift;
            cout_reg <= c_bit;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = busy_reg;
  assign done = (state_reg == S_DONE);
  assign sum  = sum_reg;
  assign cout = cout_reg;

endmodule

// File: tb/tb_serial_fadd.sv
// Self-checking bench for serial_fadd: timeline reference model checked every cycle.
module tb_serial_fadd;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n, start, cin;
  logic [W-1:0] a, b;
  logic         busy, done, cout;
  logic [W-1:0] sum;

  int checks = 0;
  int errors = 0;
  bit checking = 0;

  serial_fadd #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: a run accepted at edge k holds busy through edge k+W, publishes
  // a+b+cin at edge k+W (done that cycle) and can accept again from edge k+W+2.
  int           edge_n = 0;
  int           acc_edge = 0;
  bit           active = 0;
  logic [W:0]   res;
  logic [W-1:0] m_sum = '0;
  logic         m_cout = 1'b0, m_busy = 1'b0, m_done = 1'b0;

  always @(posedge clk) begin
    edge_n++;
    if (!rst_n) begin
      active = 0;
      m_sum  = '0;
      m_cout = 1'b0;
    end else begin
      if (!active && start) begin
        active   = 1;
        acc_edge = edge_n;
        res      = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
      end
      if (active && edge_n == acc_edge + W) begin
        m_sum  = res[W-1:0];
        m_cout = res[W];
      end
      if (active && edge_n == acc_edge + W + 1) active = 0;
    end
    m_busy = active && (edge_n <= acc_edge + W);
    m_done = active && (edge_n == acc_edge + W);
  end

  always @(negedge clk) begin
    if (checking) begin
      check("busy", 32'(busy), 32'(m_busy));
      check("done", 32'(done), 32'(m_done));
      check("sum",  32'(sum),  32'(m_sum));
      check("cout", 32'(cout), 32'(m_cout));
    end
  end

  int done_cnt = 0;
  always @(negedge clk) if (done) done_cnt++;

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                        output int n);
    a = ta; b = tb_; cin = tc; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    n = 1;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!done) check("done_timeout", 32'(done), 32'd1);
    $display("op a=%02h b=%02h cin=%0d -> sum=%02h cout=%0d cycles=%0d", ta, tb_, tc, sum, cout, n);
    @(negedge clk);
  endtask

  initial begin
    int n, d0;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(negedge clk);
    checking = 1;
    rst_n = 1'b1;
    @(negedge clk);

    // Basic add with latency check
    run_op(8'h0F, 8'h01, 1'b0, n);
    check("t1_cycles", 32'(n), 32'(W + 1));
    check("t1_sum", 32'(sum), 32'h10);
    check("t1_cout", 32'(cout), 32'h0);

    // Full carry ripple
    run_op(8'hFF, 8'h01, 1'b0, n);
    check("t2a_sum", 32'(sum), 32'h00);
    check("t2a_cout", 32'(cout), 32'h1);
    run_op(8'hFF, 8'hFF, 1'b1, n);
    check("t2b_sum", 32'(sum), 32'hFF);
    check("t2b_cout", 32'(cout), 32'h1);

    // Carry-in only, result held while idle
    run_op(8'h00, 8'h00, 1'b1, n);
    repeat (5) @(negedge clk);
    check("t3_sum_hold", 32'(sum), 32'h01);
    check("t3_cout", 32'(cout), 32'h0);

    // Start while busy is ignored
    d0 = done_cnt;
    a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    a = 8'hAA; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    check("t4_done_count", 32'(done_cnt - d0), 32'd1);
    check("t4_sum", 32'(sum), 32'h46);
    $display("busy-start test: dones=%0d sum=%02h", done_cnt - d0, sum);

    // Reset mid-run
    a = 8'h77; b = 8'h11; cin = 1'b1; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("t5_busy", 32'(busy), 32'h0);
    check("t5_sum", 32'(sum), 32'h00);
    d0 = done_cnt;
    repeat (15) @(negedge clk);
    check("t5_no_done", 32'(done_cnt - d0), 32'd0);
    $display("reset mid-run: sum=%02h cout=%0d dones=%0d", sum, cout, done_cnt - d0);

    // Back-to-back with start held high
    d0 = done_cnt;
    start = 1'b1;
    for (int i = 0; i < 60; i++) begin
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    repeat (12) @(negedge clk);
    check("t6_done_count", 32'(done_cnt - d0), 32'd6);
    $display("back-to-back: dones=%0d", done_cnt - d0);

    // Randomized operands with random idle gaps
    for (int i = 0; i < 1000; i++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), n);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
